// File: rtl/dht11_sensor_emu.sv
// DHT11 sensor emulator: answers a host start pulse on the single-wire bus with
// the DHT11 response and a 40-bit humidity/temperature/checksum frame.
module dht11_sensor_emu #(
    parameter int unsigned T_START_MIN = 800_000,
    parameter int unsigned T_RESP_DLY  = 1_500,
    parameter int unsigned T_RESP      = 4_000,
    parameter int unsigned T_BIT_LOW   = 2_500,
    parameter int unsigned T_BIT0      = 1_300,
    parameter int unsigned T_BIT1      = 3_500
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    inout  wire        dht11_data,
    input  logic [7:0] humi_int,
    input  logic [7:0] humi_deci,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_deci,
    input  logic       csum_err_inj,
    output logic       busy,
    output logic       frame_done,
    output logic       start_short
);

    localparam int unsigned T_MAX_A = (T_START_MIN > T_RESP_DLY) ? T_START_MIN : T_RESP_DLY;
    localparam int unsigned T_MAX_B = (T_RESP > T_BIT_LOW) ? T_RESP : T_BIT_LOW;
    localparam int unsigned T_MAX_C = (T_BIT0 > T_BIT1) ? T_BIT0 : T_BIT1;
    localparam int unsigned T_MAX_D = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int unsigned T_MAX   = (T_MAX_D > T_MAX_C) ? T_MAX_D : T_MAX_C;
    localparam int unsigned CW      = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        HOST_LOW,
        RESP_DLY,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [5:0]      bit_q, bit_d;
    logic [39:0]     frame_q;
    logic [1:0]      sync_q;
    logic            armed_q, armed_d;
    logic            drive_low;
    logic            capture;
    logic            done_d, short_d, drive_d, busy_d;
    logic            bus_s;
    logic            cur_bit;
    logic [5:0]      bit_pos;
    logic [CW-1:0]   phase_last;
    logic [7:0]      csum;

    assign dht11_data = drive_low ? 1'b0 : 1'bz;
    assign bus_s      = sync_q[1];
    assign bit_pos    = 6'd39 - bit_q;
    assign cur_bit    = frame_q[bit_pos];
    assign csum       = humi_int + humi_deci + temp_int + temp_deci;

    always_comb begin
        phase_last = '0;
        case (state_q)
            RESP_DLY:  phase_last = CW'(T_RESP_DLY - 1);
            RESP_LOW:  phase_last = CW'(T_RESP - 1);
            RESP_HIGH: phase_last = CW'(T_RESP - 1);
            BIT_LOW:   phase_last = CW'(T_BIT_LOW - 1);
            BIT_HIGH:  phase_last = cur_bit ? CW'(T_BIT1 - 1) : CW'(T_BIT0 - 1);
            END_LOW:   phase_last = CW'(T_BIT_LOW - 1);
            default:   phase_last = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        armed_d = armed_q;
        capture = 1'b0;
        done_d  = 1'b0;
        short_d = 1'b0;
        case (state_q)
            IDLE: begin
                // A start is only accepted after the line has been seen high since IDLE entry.
                if (bus_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = HOST_LOW;
                    cnt_d   = '0;
                end
            end
            HOST_LOW: begin
                if (!bus_s) begin
                    if (cnt_q < CW'(T_START_MIN)) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (cnt_q >= CW'(T_START_MIN)) begin
                    state_d = RESP_DLY;
                    cnt_d   = '0;
                    capture = 1'b1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    short_d = 1'b1;
                    armed_d = 1'b0;
                end
            end
            default: begin
                if (cnt_q == phase_last) begin
                    cnt_d = '0;
                    case (state_q)
                        RESP_DLY:  state_d = RESP_LOW;
                        RESP_LOW:  state_d = RESP_HIGH;
                        RESP_HIGH: begin
                            state_d = BIT_LOW;
                            bit_d   = '0;
                        end
                        BIT_LOW:   state_d = BIT_HIGH;
                        BIT_HIGH: begin
                            if (bit_q == 6'd39) begin
                                state_d = END_LOW;
                            end else begin
                                state_d = BIT_LOW;
                                bit_d   = bit_q + 6'd1;
                            end
                        end
                        END_LOW: begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            armed_d = 1'b0;
                        end
                        default:   state_d = IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
        drive_d = (state_d == RESP_LOW) || (state_d == BIT_LOW) || (state_d == END_LOW);
        busy_d  = (state_d != IDLE) && (state_d != HOST_LOW);
    end

    // Outputs are registered from the next state so they line up with state_q exactly.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            frame_q     <= '0;
            sync_q      <= '1;
            armed_q     <= 1'b0;
            drive_low   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            start_short <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sync_q      <= {sync_q[0], dht11_data};
            armed_q     <= armed_d;
            drive_low   <= drive_d;
            busy        <= busy_d;
            frame_done  <= done_d;
            start_short <= short_d;
            if (capture) begin
                frame_q <= {humi_int, humi_deci, temp_int, temp_deci, csum ^ {8{csum_err_inj}}};
            end
        end
    end

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Self-checking bench for dht11_sensor_emu: a host model drives start pulses and
// a bus-side run-length decoder recovers the response timing and 40-bit frame.
module tb_dht11_sensor_emu;

    localparam int unsigned SM = 40;
    localparam int unsigned RD = 6;
    localparam int unsigned RS = 16;
    localparam int unsigned BL = 10;
    localparam int unsigned B0 = 5;
    localparam int unsigned B1 = 14;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       host_low = 1'b0;
    logic [7:0] humi_int = '0, humi_deci = '0, temp_int = '0, temp_deci = '0;
    logic       csum_err_inj = 1'b0;
    logic       busy, frame_done, start_short;
    wire        dht11_data;

    pullup (dht11_data);
    assign dht11_data = host_low ? 1'b0 : 1'bz;

    dht11_sensor_emu #(
        .T_START_MIN(SM), .T_RESP_DLY(RD), .T_RESP(RS),
        .T_BIT_LOW(BL), .T_BIT0(B0), .T_BIT1(B1)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .dht11_data(dht11_data),
        .humi_int(humi_int), .humi_deci(humi_deci), .temp_int(temp_int), .temp_deci(temp_deci),
        .csum_err_inj(csum_err_inj), .busy(busy), .frame_done(frame_done), .start_short(start_short)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic lvl;
        int   len;
    } run_t;

    run_t runs[$];
    logic cur_lvl = 1'b1;
    int   cur_len = 0;
    int   done_cnt = 0, short_cnt = 0, drove_cnt = 0, busy_cnt = 0, fall_cnt = 0;
    int   n_cmp = 0, n_err = 0;

    // Bus run-length recorder, sampled on the falling edge away from DUT updates.
    always @(negedge sys_clk) begin
        if (dht11_data == cur_lvl) begin
            cur_len = cur_len + 1;
        end else begin
            runs.push_back('{cur_lvl, cur_len});
            if (cur_lvl == 1'b1 && !host_low) fall_cnt = fall_cnt + 1;
            cur_lvl = dht11_data;
            cur_len = 1;
        end
        if (dht11_data == 1'b0 && !host_low) drove_cnt = drove_cnt + 1;
        if (frame_done)  done_cnt  = done_cnt + 1;
        if (start_short) short_cnt = short_cnt + 1;
        if (busy)        busy_cnt  = busy_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic decode(input int from, output logic ok, output logic [39:0] val,
                          output int dly, output int rl, output int rh, output int badw);
        int   i;
        int   hw, ew;
        logic b;
        ok = 1'b0; val = '0; dly = 0; rl = 0; rh = 0; badw = 0;
        i = from;
        while (i < runs.size() && !(runs[i].lvl == 1'b0 && runs[i].len >= int'(SM))) i++;
        if (i + 84 >= runs.size()) return;
        dly = runs[i+1].len;
        rl  = runs[i+2].len;
        rh  = runs[i+3].len;
        for (int k = 0; k < 40; k++) begin
            hw  = runs[i+5+2*k].len;
            b   = (hw > int'((B0 + B1) / 2));
            val = {val[38:0], b};
            ew  = b ? int'(B1) : int'(B0);
            if (runs[i+4+2*k].len != int'(BL) || hw + 1 < ew || hw > ew + 1) badw++;
        end
        if (runs[i+84].len != int'(BL)) badw++;
        ok = 1'b1;
    endtask

    task automatic host_start(input int width);
        host_low = 1'b1;
        tick(width);
        host_low = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int c = 0; c < 3000 && done_cnt == d0; c++) tick(1);
        check("frame_done_seen", (done_cnt != d0), 1'b1);
    endtask

    typedef struct {
        logic [7:0]  h, hd, t, td;
        logic        inj;
        logic [39:0] exp;
        logic        valid;
    } vec_t;

    vec_t vt[5];

    task automatic run_frame(input vec_t v, input string tag);
        int          from, d0, dly, rl, rh, badw;
        logic        ok, hv;
        logic [39:0] val;
        logic [7:0]  s;
        humi_int = v.h; humi_deci = v.hd; temp_int = v.t; temp_deci = v.td;
        csum_err_inj = v.inj;
        from = runs.size();
        d0   = done_cnt;
        host_start(SM + 10);
        for (int c = 0; c < 100 && !busy; c++) tick(1);
        check({tag, "_busy_rise"}, busy, 1'b1);
        // Inputs scrambled mid-frame must not leak into the frame in flight.
        humi_int = ~v.h; humi_deci = ~v.hd; temp_int = ~v.t; temp_deci = ~v.td;
        csum_err_inj = ~v.inj;
        wait_done(d0);
        tick(20);
        decode(from, ok, val, dly, rl, rh, badw);
        s  = val[39:32] + val[31:24] + val[23:16] + val[15:8];
        hv = ok && (s == val[7:0]);
        check({tag, "_decoded"}, ok, 1'b1);
        check({tag, "_frame"}, val, v.exp);
        check({tag, "_host_valid"}, hv, v.valid);
        check({tag, "_resp_low"}, rl, RS);
        check({tag, "_resp_high"}, rh, RS);
        check({tag, "_resp_dly"}, (dly >= int'(RD) + 2 && dly <= int'(RD) + 4), 1'b1);
        check({tag, "_bit_widths_bad"}, badw, 0);
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_busy_clear"}, busy, 1'b0);
    endtask

    initial begin
        int d0, s0, dr0, b0, f0;
        vt[0] = '{8'd45,  8'd0,   8'd23,  8'd5,   1'b0, 40'h2D_00_17_05_49, 1'b1};
        vt[1] = '{8'hFF,  8'hFF,  8'hFF,  8'hFF,  1'b0, 40'hFF_FF_FF_FF_FC, 1'b1};
        vt[2] = '{8'd1,   8'd2,   8'd3,   8'd4,   1'b1, 40'h01_02_03_04_F5, 1'b0};
        vt[3] = '{8'h80,  8'h80,  8'h80,  8'h80,  1'b0, 40'h80_80_80_80_00, 1'b1};
        vt[4] = '{8'h00,  8'h00,  8'h00,  8'h00,  1'b1, 40'h00_00_00_00_FF, 1'b0};

        tick(5);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_start_short", start_short, 1'b0);
        check("rst_bus_released", dht11_data, 1'b1);
        sys_rst = 1'b0;
        tick(10);

        s0 = short_cnt; dr0 = drove_cnt; b0 = busy_cnt;
        host_start(SM - 10);
        tick(20);
        check("short_pulse_count", short_cnt - s0, 1);
        check("short_bus_driven", drove_cnt - dr0, 0);
        check("short_busy_cycles", busy_cnt - b0, 0);

        for (int i = 0; i < 5; i++) begin
            run_frame(vt[i], $sformatf("vec%0d", i));
            tick(10);
        end

        humi_int = 8'd45; humi_deci = 8'd0; temp_int = 8'd23; temp_deci = 8'd5;
        csum_err_inj = 1'b0;
        d0 = done_cnt;
        host_start(SM + 10);
        f0 = fall_cnt;
        for (int c = 0; c < 2000 && fall_cnt < f0 + 22; c++) tick(1);
        check("bit20_reached", (fall_cnt >= f0 + 22), 1'b1);
        tick(3);
        check("bit20_low", dht11_data, 1'b0);
        sys_rst = 1'b1;
        tick(1);
        check("midrst_bus_released", dht11_data, 1'b1);
        check("midrst_busy", busy, 1'b0);
        sys_rst = 1'b0;
        tick(300);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_busy_after", busy, 1'b0);
        run_frame(vt[0], "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
